// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard control.
// Registers decoded operands/control from ID, resolves ALU A/B through EX/MEM
// and MEM/WB forwarding, turns load-use hazards into bubbles, and keeps a
// saturating count of inserted bubbles for debug.
module id_ex_stage #(
  parameter int unsigned CNT_W    = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [31:0]      id_pc,
  input  logic [4:0]       id_rs_addr,
  input  logic             id_use_rs,
  input  logic [4:0]       id_rt_addr,
  input  logic             id_use_rt,
  input  logic [31:0]      id_rs_data,
  input  logic [31:0]      id_rt_data,
  input  logic [31:0]      id_imm32,
  input  logic             id_alusrc,
  input  logic [2:0]       id_aluop,
  input  logic [4:0]       id_wr_addr,
  input  logic             id_reg_write,
  input  logic             id_mem_to_reg,
  input  logic             flush,
  input  logic             mem_fwd_en,
  input  logic [4:0]       mem_fwd_addr,
  input  logic [31:0]      mem_fwd_data,
  input  logic             wb_fwd_en,
  input  logic [4:0]       wb_fwd_addr,
  input  logic [31:0]      wb_fwd_data,
  output logic             stall,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [2:0]       alu_op,
  output logic [31:0]      ex_store_data,
  output logic             ex_valid,
  output logic             ex_reg_write,
  output logic             ex_mem_to_reg,
  output logic [4:0]       ex_wr_addr,
  output logic [31:0]      ex_pc,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [1:0] {
    ACT_CAPTURE,
    ACT_IDLE,
    ACT_HAZARD,
    ACT_FLUSH
  } act_t;

  act_t        act;
  logic        hazard;
  logic [31:0] cap_rs, cap_rt;
  logic [4:0]  ex_rs_addr, ex_rt_addr;
  logic [31:0] ex_rs_val, ex_rt_val, ex_imm;
  logic        ex_alusrc;
  logic [31:0] fwd_rs, fwd_rt;

  // Register 0 is hard-wired, so it is never a forwarding target.
  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] v,
                                      input logic me, input logic [4:0] ma,
                                      input logic [31:0] md, input logic we,
                                      input logic [4:0] wa, input logic [31:0] wd);
    if (a != 5'd0 && me && ma == a)      return md;
    else if (a != 5'd0 && we && wa == a) return wd;
    else                                 return v;
  endfunction

  // Load-use hazard detection and per-edge action selection (flush > hazard > capture).
  always_comb begin
    hazard = ex_valid && ex_mem_to_reg && (ex_wr_addr != 5'd0) && id_valid &&
             ((id_use_rs && id_rs_addr == ex_wr_addr) ||
              (id_use_rt && id_rt_addr == ex_wr_addr));
    stall  = hazard && !flush;
    if (flush)          act = ACT_FLUSH;
    else if (hazard)    act = ACT_HAZARD;
    else if (!id_valid) act = ACT_IDLE;
    else                act = ACT_CAPTURE;
  end

  // Capture-time bypass: a write-back landing this cycle replaces the stale GRF read.
  always_comb begin
    cap_rs = (wb_fwd_en && id_rs_addr != 5'd0 && wb_fwd_addr == id_rs_addr) ? wb_fwd_data : id_rs_data;
    cap_rt = (wb_fwd_en && id_rt_addr != 5'd0 && wb_fwd_addr == id_rt_addr) ? wb_fwd_data : id_rt_data;
  end

  // ID/EX pipeline register: capture a real instruction, otherwise load a zeroed bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_wr_addr    <= '0;
      alu_op        <= '0;
      ex_pc         <= RESET_PC;
      ex_rs_addr    <= '0;
      ex_rt_addr    <= '0;
      ex_rs_val     <= '0;
      ex_rt_val     <= '0;
      ex_imm        <= '0;
      ex_alusrc     <= 1'b0;
    end else if (act == ACT_CAPTURE) begin
      ex_valid      <= 1'b1;
      ex_reg_write  <= id_reg_write;
      ex_mem_to_reg <= id_mem_to_reg;
      ex_wr_addr    <= id_wr_addr;
      alu_op        <= id_aluop;
      ex_pc         <= id_pc;
      ex_rs_addr    <= id_rs_addr;
      ex_rt_addr    <= id_rt_addr;
      ex_rs_val     <= cap_rs;
      ex_rt_val     <= cap_rt;
      ex_imm        <= id_imm32;
      ex_alusrc     <= id_alusrc;
    end else begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_wr_addr    <= '0;
      alu_op        <= '0;
      ex_pc         <= RESET_PC;
      ex_rs_addr    <= '0;
      ex_rt_addr    <= '0;
      ex_rs_val     <= '0;
      ex_rt_val     <= '0;
      ex_imm        <= '0;
      ex_alusrc     <= 1'b0;
    end
  end

  // Saturating count of hazard and flush bubbles; idle slots are not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bubble_cnt <= '0;
    else if ((act == ACT_FLUSH || act == ACT_HAZARD) && bubble_cnt != '1)
      bubble_cnt <= bubble_cnt + 1'b1;
  end

  // EX-stage operand forwarding: MEM beats WB beats the registered value.
  always_comb begin
    fwd_rs = fwd(ex_rs_addr, ex_rs_val, mem_fwd_en, mem_fwd_addr, mem_fwd_data,
                 wb_fwd_en, wb_fwd_addr, wb_fwd_data);
    fwd_rt = fwd(ex_rt_addr, ex_rt_val, mem_fwd_en, mem_fwd_addr, mem_fwd_data,
                 wb_fwd_en, wb_fwd_addr, wb_fwd_data);
    alu_a         = fwd_rs;
    alu_b         = ex_alusrc ? ex_imm : fwd_rt;
    ex_store_data = fwd_rt;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: pipeline capture, load-use stall,
// forwarding priority, flush/hazard interaction, async reset, counter saturation.
module tb_id_ex_stage;

  localparam logic [31:0] RPC = 32'h0000_3000;
  localparam logic [2:0]  OP_ADD = 3'd2;
  localparam logic [2:0]  OP_SUB = 3'd3;

  logic clk, rst_n;
  logic id_valid, id_use_rs, id_use_rt, id_alusrc, id_reg_write, id_mem_to_reg, flush;
  logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm32;
  logic [4:0]  id_rs_addr, id_rt_addr, id_wr_addr;
  logic [2:0]  id_aluop;
  logic        mem_fwd_en, wb_fwd_en;
  logic [4:0]  mem_fwd_addr, wb_fwd_addr;
  logic [31:0] mem_fwd_data, wb_fwd_data;

  logic stall, ex_valid, ex_reg_write, ex_mem_to_reg;
  logic [31:0] alu_a, alu_b, ex_store_data, ex_pc;
  logic [2:0]  alu_op;
  logic [4:0]  ex_wr_addr;
  logic [15:0] bubble_cnt;

  logic s_stall, s_ex_valid, s_ex_reg_write, s_ex_mem_to_reg;
  logic [31:0] s_alu_a, s_alu_b, s_ex_store_data, s_ex_pc;
  logic [2:0]  s_alu_op;
  logic [4:0]  s_ex_wr_addr;
  logic [1:0]  s_bubble_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  id_ex_stage #(.CNT_W(16), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs_addr(id_rs_addr), .id_use_rs(id_use_rs), .id_rt_addr(id_rt_addr), .id_use_rt(id_use_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm32(id_imm32), .id_alusrc(id_alusrc),
    .id_aluop(id_aluop), .id_wr_addr(id_wr_addr), .id_reg_write(id_reg_write),
    .id_mem_to_reg(id_mem_to_reg), .flush(flush),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_en(wb_fwd_en), .wb_fwd_addr(wb_fwd_addr), .wb_fwd_data(wb_fwd_data),
    .stall(stall), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_store_data(ex_store_data),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_wr_addr(ex_wr_addr), .ex_pc(ex_pc), .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.CNT_W(2), .RESET_PC(RPC)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs_addr(id_rs_addr), .id_use_rs(id_use_rs), .id_rt_addr(id_rt_addr), .id_use_rt(id_use_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm32(id_imm32), .id_alusrc(id_alusrc),
    .id_aluop(id_aluop), .id_wr_addr(id_wr_addr), .id_reg_write(id_reg_write),
    .id_mem_to_reg(id_mem_to_reg), .flush(flush),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_en(wb_fwd_en), .wb_fwd_addr(wb_fwd_addr), .wb_fwd_data(wb_fwd_data),
    .stall(s_stall), .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_op(s_alu_op), .ex_store_data(s_ex_store_data),
    .ex_valid(s_ex_valid), .ex_reg_write(s_ex_reg_write), .ex_mem_to_reg(s_ex_mem_to_reg),
    .ex_wr_addr(s_ex_wr_addr), .ex_pc(s_ex_pc), .bubble_cnt(s_bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [31:0] pc, input logic [4:0] rs, input logic urs, input logic [31:0] rsd,
                        input logic [4:0] rt, input logic urt, input logic [31:0] rtd,
                        input logic [4:0] wr, input logic load);
    id_valid = 1'b1; id_pc = pc;
    id_rs_addr = rs; id_use_rs = urs; id_rs_data = rsd;
    id_rt_addr = rt; id_use_rt = urt; id_rt_data = rtd;
    id_wr_addr = wr; id_reg_write = 1'b1; id_mem_to_reg = load;
    id_alusrc = 1'b0; id_imm32 = '0; id_aluop = OP_ADD;
  endtask

  initial begin
    rst_n = 1'b1;
    id_valid = 0; id_pc = '0; id_rs_addr = '0; id_use_rs = 0; id_rt_addr = '0; id_use_rt = 0;
    id_rs_data = '0; id_rt_data = '0; id_imm32 = '0; id_alusrc = 0; id_aluop = '0;
    id_wr_addr = '0; id_reg_write = 0; id_mem_to_reg = 0; flush = 0;
    mem_fwd_en = 0; mem_fwd_addr = '0; mem_fwd_data = '0;
    wb_fwd_en = 0; wb_fwd_addr = '0; wb_fwd_data = '0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
    check("rst_alu_op", {29'b0, alu_op}, 32'd0);
    check("rst_wr_addr", {27'b0, ex_wr_addr}, 32'd0);
    check("rst_bubble_cnt", {16'b0, bubble_cnt}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_ex_pc", ex_pc, RPC);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    #4 rst_n = 1'b1;

    // Plain ADD capture, no forwarding
    set_id(32'h100, 5'd1, 1, 32'd5, 5'd2, 1, 32'd3, 5'd3, 0);
    step();
    check("add_alu_a", alu_a, 32'd5);
    check("add_alu_b", alu_b, 32'd3);
    check("add_alu_op", {29'b0, alu_op}, {29'b0, OP_ADD});
    check("add_ex_valid", {31'b0, ex_valid}, 32'd1);
    check("add_ex_pc", ex_pc, 32'h100);
    check("add_wr_addr", {27'b0, ex_wr_addr}, 32'd3);
    check("add_store", ex_store_data, 32'd3);

    // Load to $4 followed by a use of $4
    set_id(32'h104, 5'd1, 1, 32'd5, 5'd0, 0, 32'd0, 5'd4, 1);
    step();
    check("ld_mem_to_reg", {31'b0, ex_mem_to_reg}, 32'd1);
    set_id(32'h108, 5'd4, 1, 32'h77, 5'd2, 1, 32'd3, 5'd5, 0);
    id_aluop = OP_SUB;
    #1;
    check("lu_stall", {31'b0, stall}, 32'd1);
    step();
    check("lu_bubble_valid", {31'b0, ex_valid}, 32'd0);
    check("lu_bubble_pc", ex_pc, RPC);
    check("lu_bubble_op", {29'b0, alu_op}, 32'd0);
    check("lu_bubble_wr", {27'b0, ex_wr_addr}, 32'd0);
    check("lu_bubble_cnt", {16'b0, bubble_cnt}, 32'd1);
    check("lu_stall_drop", {31'b0, stall}, 32'd0);
    step();
    check("lu_cap_valid", {31'b0, ex_valid}, 32'd1);
    check("lu_cap_pc", ex_pc, 32'h108);
    check("lu_cap_alu_a", alu_a, 32'h77);
    check("lu_cap_op", {29'b0, alu_op}, {29'b0, OP_SUB});
    check("lu_cnt_hold", {16'b0, bubble_cnt}, 32'd1);

    // EX forwarding priority on rs=$4
    id_valid = 1'b0;
    mem_fwd_en = 1; mem_fwd_addr = 5'd4; mem_fwd_data = 32'hAAAA;
    wb_fwd_en = 1; wb_fwd_addr = 5'd4; wb_fwd_data = 32'hBBBB;
    #1 check("fwd_mem_wins", alu_a, 32'hAAAA);
    check("fwd_rt_untouched", alu_b, 32'd3);
    mem_fwd_en = 0;
    #1 check("fwd_wb", alu_a, 32'hBBBB);
    wb_fwd_en = 0;
    #1 check("fwd_none", alu_a, 32'h77);
    mem_fwd_en = 1; mem_fwd_addr = 5'd2; mem_fwd_data = 32'hCCCC;
    #1 check("fwd_rt_b", alu_b, 32'hCCCC);
    check("fwd_rt_store", ex_store_data, 32'hCCCC);
    mem_fwd_en = 0;

    // Capture-time WB bypass on rs, immediate operand on B
    set_id(32'h10C, 5'd6, 1, 32'h11, 5'd2, 1, 32'd3, 5'd7, 0);
    id_alusrc = 1; id_imm32 = 32'h1234;
    wb_fwd_en = 1; wb_fwd_addr = 5'd6; wb_fwd_data = 32'h66;
    step();
    wb_fwd_en = 0;
    #1;
    check("bypass_alu_a", alu_a, 32'h66);
    check("imm_alu_b", alu_b, 32'h1234);
    check("imm_store", ex_store_data, 32'd3);

    // Hazard and flush together
    set_id(32'h110, 5'd1, 1, 32'd5, 5'd0, 0, 32'd0, 5'd7, 1);
    step();
    set_id(32'h114, 5'd7, 1, 32'd0, 5'd0, 0, 32'd0, 5'd8, 0);
    flush = 1;
    #1 check("hf_stall", {31'b0, stall}, 32'd0);
    step();
    flush = 0;
    check("hf_valid", {31'b0, ex_valid}, 32'd0);
    check("hf_pc", ex_pc, RPC);
    check("hf_cnt", {16'b0, bubble_cnt}, 32'd2);

    // Idle slot: bubble without counting
    id_valid = 0;
    step();
    check("idle_valid", {31'b0, ex_valid}, 32'd0);
    check("idle_cnt", {16'b0, bubble_cnt}, 32'd2);

    // Register 0 never forwarded, not even at capture
    set_id(32'h118, 5'd0, 1, 32'd0, 5'd0, 1, 32'd0, 5'd9, 0);
    mem_fwd_en = 1; mem_fwd_addr = 5'd0; mem_fwd_data = 32'hFFFF_FFFF;
    wb_fwd_en = 1; wb_fwd_addr = 5'd0; wb_fwd_data = 32'hFFFF_FFFF;
    step();
    check("r0_valid", {31'b0, ex_valid}, 32'd1);
    check("r0_alu_a", alu_a, 32'd0);
    check("r0_alu_b", alu_b, 32'd0);
    mem_fwd_en = 0; wb_fwd_en = 0;

    // Asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'b0, ex_valid}, 32'd0);
    check("arst_pc", ex_pc, RPC);
    check("arst_wr", {27'b0, ex_wr_addr}, 32'd0);
    check("arst_cnt", {16'b0, bubble_cnt}, 32'd0);
    check("arst_cnt_sat", {30'b0, s_bubble_cnt}, 32'd0);
    #3 rst_n = 1'b1;
    set_id(32'h200, 5'd1, 1, 32'h42, 5'd2, 1, 32'h24, 5'd3, 0);
    step();
    check("post_rst_valid", {31'b0, ex_valid}, 32'd1);
    check("post_rst_pc", ex_pc, 32'h200);
    check("post_rst_alu_a", alu_a, 32'h42);

    // Saturation of the 2-bit counter via flush bubbles
    flush = 1;
    step();
    check("sat_1", {30'b0, s_bubble_cnt}, 32'd1);
    step();
    check("sat_2", {30'b0, s_bubble_cnt}, 32'd2);
    step();
    check("sat_3", {30'b0, s_bubble_cnt}, 32'd3);
    step();
    check("sat_hold", {30'b0, s_bubble_cnt}, 32'd3);
    check("wide_cnt_4", {16'b0, bubble_cnt}, 32'd4);
    flush = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
